// File: rtl/mem_stage_access_unit_if.sv
// Single-outstanding data-memory bus between the MEM-stage access unit and data memory.
interface mem_stage_access_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ready;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: issues one bus access per load/store, stalls the
// pipeline while it is in flight and returns lane-extracted, extended load data.
module mem_stage_access_unit #(
    parameter int XLEN = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     memwriteM_i,
    input  logic [1:0]               resultsrcM_i,
    input  logic [2:0]               funct3M_i,
    input  logic [XLEN-1:0]          aluresultM_i,
    input  logic [XLEN-1:0]          writedataM_i,
    mem_stage_access_unit_if.master  dmem,
    output logic [XLEN-1:0]          readdataM_o,
    output logic                     stallM_o,
    output logic                     access_fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic is_load, access, misalign, bad_funct3, fault, go, issue, complete;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        b_s = word[{off, 3'b000} +: 8];
        h_s = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return 32'(b_s);
            3'b001:  return 32'(h_s);
            3'b100:  return {24'b0, b_s};
            3'b101:  return {16'b0, h_s};
            default: return word;
        endcase
    endfunction

    // Decode: a store wins over a load when both are flagged.
    always_comb begin
        is_load    = (resultsrcM_i == 2'b01);
        access     = memwriteM_i | is_load;
        misalign   = ((funct3M_i[1:0] == 2'b01) && aluresultM_i[0]) ||
                     ((funct3M_i[1:0] == 2'b10) && (aluresultM_i[1:0] != 2'b00));
        bad_funct3 = memwriteM_i ? !(funct3M_i inside {3'b000, 3'b001, 3'b010})
                                 : (funct3M_i inside {3'b011, 3'b110, 3'b111});
        fault      = misalign | bad_funct3;
        go         = access & ~fault;
        issue      = (state_q == IDLE) & go;
        complete   = (state_q == REQ) & dmem.ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (dmem.ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= memwriteM_i;
                addr_q  <= {aluresultM_i[XLEN-1:2], 2'b00};
                be_q    <= lane_be(funct3M_i, aluresultM_i[1:0]);
                wdata_q <= lane_wdata(funct3M_i, writedataM_i);
            end
            // EX/MEM inputs are frozen by the stall, so the byte offset is still valid here.
            if (complete) begin
                req_q <= 1'b0;
                if (!we_q) rdata_q <= load_extend(funct3M_i, aluresultM_i[1:0], dmem.rdata);
            end
        end
    end

    assign dmem.req       = req_q;
    assign dmem.we        = we_q;
    assign dmem.addr      = addr_q;
    assign dmem.be        = be_q;
    assign dmem.wdata     = wdata_q;
    assign readdataM_o    = rdata_q;
    assign stallM_o       = issue | (state_q == REQ);
    assign access_fault_o = (state_q == IDLE) & access & fault;

endmodule
